reg_bus_arbiter: RTL and testbench
==================================

Name: reg_bus_arbiter

Overview:
- Shares one CPU register-access bus (req/rd_wr_L/addr/wr_data in; ack/rd_data back) between NUM_MASTERS requesters, e.g. the PCI-side FIFO sequencer and an on-chip DMA/config engine.
- Sits upstream of the register decode/mux group and presents a single master to it.
- Round-robin grant, one outstanding access at a time, built-in access timeout.

Parameters:
- NUM_MASTERS, 2, number of requesters (2..8).
- ADDR_WIDTH, 25, word address width (CPCI_NF2_ADDR_WIDTH-2).
- DATA_WIDTH, 32, data width.
- TIMEOUT, 511, cycles to wait for downstream ack before aborting.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- mst_req  in  NUM_MASTERS  per-master request; held high until mst_ack.
- mst_rd_wr_L  in  NUM_MASTERS  1=read, 0=write.
- mst_addr  in  NUM_MASTERS*ADDR_WIDTH  packed word addresses; master i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- mst_wr_data  in  NUM_MASTERS*DATA_WIDTH  packed write data.
- mst_ack  out  NUM_MASTERS  one-cycle completion pulse to the granted master.
- mst_rd_data  out  DATA_WIDTH  read data, valid with any mst_ack bit.
- mst_timeout  out  1  pulses with mst_ack when the access timed out.
- reg_req  out  1  downstream request.
- reg_rd_wr_L  out  1  downstream direction.
- reg_addr  out  ADDR_WIDTH  downstream word address.
- reg_wr_data  out  DATA_WIDTH  downstream write data.
- reg_ack  in  1  downstream completion.
- reg_rd_data  in  DATA_WIDTH  downstream read data, valid with reg_ack.

Behaviour:
- Reset (asynchronous, reset low):
  - state=IDLE, rr_ptr=0, all outputs 0 except reg_rd_wr_L=1.
  - Timeout counter=0, mst_rd_data=0.
- Reset asserted mid-access: the access is abandoned. No mst_ack is produced. reg_req drops immediately.
- IDLE:
  - If any mst_req is high, grant the first requesting master at or after rr_ptr (cyclic search).
  - Latch that master's rd_wr_L, addr and wr_data (write data forced to 0 for reads).
  - Load the counter with TIMEOUT and go to WAIT_ACK.
  - reg_req rises on the cycle after the request is sampled, so latency req→reg_req is 1 cycle.
- WAIT_ACK:
  - reg_req, reg_addr, reg_rd_wr_L and reg_wr_data are held stable.
  - The counter decrements each cycle.
  - reg_ack=1 → capture reg_rd_data, go to RESP.
  - Counter==0 without ack → capture 32'hDEADBEEF, set the timeout flag, go to RESP.
  - reg_ack and counter==0 in the same cycle: ack wins, no timeout.
- RESP (1 cycle):
  - reg_req=0; mst_ack[grant]=1; mst_rd_data=captured data; mst_timeout=flag.
  - mst_rd_data=0 for writes.
  - rr_ptr ← grant+1, wrapping modulo NUM_MASTERS.
  - Go to TURN.
- TURN (1 cycle): masters drop req here; the downstream ack must clear. Go to IDLE.
  - A master re-raising req in TURN is arbitrated normally in IDLE.
  - Minimum back-to-back access spacing: 3 cycles plus downstream latency.
- Stray inputs:
  - reg_ack while not in WAIT_ACK is ignored.
  - A mst_req withdrawn before grant is simply not served.
  - A mst_req withdrawn after grant still completes; the ack pulse is issued anyway.
- Fairness: a master that requests continuously waits at most NUM_MASTERS-1 accesses.
- mst_ack is one-hot or zero at all times.

Optional Feature:
- REG_BUS_ARBITER_STATS_EN defined:
  - Adds output stat_timeouts [15:0]: saturating count of timed-out accesses.
  - Adds output stat_grants [NUM_MASTERS*16-1:0]: per-master saturating grant counts.
  - Both counters clear on reset only.
- Macro undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/defines file holds:
  - State encodings: IDLE=2'd0, WAIT_ACK=2'd1, RESP=2'd2, TURN=2'd3.
  - Timeout data constant 32'hDEADBEEF.
  - Default TIMEOUT value.
- Sub-module rr_grant_sel (combinational):
  - Inputs: request vector, rr_ptr.
  - Outputs: one-hot grant and grant index.
  - Reusable by other arbiters.

Test Plan:
- Single read: master0 req, addr=25'h0400010, reg_ack after 4 cycles with data 32'h12345678 → reg_req high 1 cycle after req; mst_ack[0] pulse with mst_rd_data=32'h12345678, mst_timeout=0.
- Write: master1 write addr=25'h0000004, data=32'hCAFEF00D → reg_wr_data=32'hCAFEF00D, reg_rd_wr_L=0 held until ack; mst_ack[1] pulse, mst_rd_data=0.
- Contention: both masters request continuously for 6 accesses, rr_ptr=0 → grants alternate 0,1,0,1,0,1; never two mst_ack bits high.
- Timeout: TIMEOUT=511, reg_ack never asserted → mst_ack 513 cycles after reg_req rise; mst_rd_data=32'hDEADBEEF, mst_timeout=1; stat_timeouts=1 if REG_BUS_ARBITER_STATS_EN.
- Ack at timeout boundary: reg_ack asserted exactly when counter==0 → real data returned, mst_timeout=0.
- Reset mid-access: reset low during WAIT_ACK → reg_req=0 and state=IDLE immediately, no mst_ack; a new request after release is served normally.

Source files
------------

// File: rtl/reg_bus_arbiter_pkg.sv
// rtl/reg_bus_arbiter_pkg.sv - shared state encoding and constants for reg_bus_arbiter
package reg_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    RESP     = 2'd2,
    TURN     = 2'd3
  } arb_state_t;

  localparam logic [31:0] TIMEOUT_DATA    = 32'hDEADBEEF;
  localparam int          DEFAULT_TIMEOUT = 511;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_bus_arbiter_rr_grant_sel.sv
// rtl/reg_bus_arbiter_rr_grant_sel.sv - combinational round-robin pick: first request at or after i_ptr
module rr_grant_sel
  import reg_bus_arbiter_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = ptr_width(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_idx,
  output logic          o_valid
);

  logic [PW-1:0] w_pos;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_pos   = i_ptr;
    for (int k = 0; k < N; k++) begin
      if (!o_valid && i_req[w_pos]) begin
        o_valid        = 1'b1;
        o_idx          = w_pos;
        o_grant[w_pos] = 1'b1;
      end
      w_pos = (w_pos == PW'(N - 1)) ? '0 : w_pos + 1'b1;
    end
  end

endmodule

// File: rtl/reg_bus_arbiter.sv
// rtl/reg_bus_arbiter.sv - round-robin arbiter sharing one register bus among NUM_MASTERS requesters
// Optional per-master grant / timeout statistics under REG_BUS_ARBITER_STATS_EN.
module reg_bus_arbiter
  import reg_bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 25,
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT     = DEFAULT_TIMEOUT
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_MASTERS-1:0]           mst_req,
  input  logic [NUM_MASTERS-1:0]           mst_rd_wr_L,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] mst_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] mst_wr_data,
  output logic [NUM_MASTERS-1:0]           mst_ack,
  output logic [DATA_WIDTH-1:0]            mst_rd_data,
  output logic                             mst_timeout,
`ifdef REG_BUS_ARBITER_STATS_EN
  output logic [15:0]                      stat_timeouts,
  output logic [NUM_MASTERS*16-1:0]        stat_grants,
`endif
  output logic                             reg_req,
  output logic                             reg_rd_wr_L,
  output logic [ADDR_WIDTH-1:0]            reg_addr,
  output logic [DATA_WIDTH-1:0]            reg_wr_data,
  input  logic                             reg_ack,
  input  logic [DATA_WIDTH-1:0]            reg_rd_data
);

  localparam int PW = ptr_width(NUM_MASTERS);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  arb_state_t              r_state;
  logic [PW-1:0]           r_rr_ptr;
  logic [PW-1:0]           r_grant_idx;
  logic [NUM_MASTERS-1:0]  r_grant_oh;
  logic [CW-1:0]           r_cnt;
  logic [DATA_WIDTH-1:0]   r_data;
  logic                    r_to_flag;
  logic                    r_reg_req;
  logic                    r_reg_rd_wr_L;
  logic [ADDR_WIDTH-1:0]   r_reg_addr;
  logic [DATA_WIDTH-1:0]   r_reg_wr_data;
  logic [NUM_MASTERS-1:0]  r_mst_ack;
  logic [DATA_WIDTH-1:0]   r_mst_rd_data;
  logic                    r_mst_timeout;

  logic [NUM_MASTERS-1:0]  w_grant;
  logic [PW-1:0]           w_idx;
  logic                    w_valid;
  logic                    w_timeout;

  rr_grant_sel #(
    .N  (NUM_MASTERS),
    .PW (PW)
  ) u_rr_grant_sel (
    .i_req   (mst_req),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );

  // Ack has priority over expiry when both land on the same cycle.
  assign w_timeout = (r_state == WAIT_ACK) && !reg_ack && (r_cnt == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_rr_ptr      <= '0;
      r_grant_idx   <= '0;
      r_grant_oh    <= '0;
      r_cnt         <= '0;
      r_data        <= '0;
      r_to_flag     <= 1'b0;
      r_reg_req     <= 1'b0;
      r_reg_rd_wr_L <= 1'b1;
      r_reg_addr    <= '0;
      r_reg_wr_data <= '0;
      r_mst_ack     <= '0;
      r_mst_rd_data <= '0;
      r_mst_timeout <= 1'b0;
    end else begin
      r_mst_ack     <= '0;
      r_mst_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_grant_idx   <= w_idx;
            r_grant_oh    <= w_grant;
            r_reg_req     <= 1'b1;
            r_reg_rd_wr_L <= mst_rd_wr_L[w_idx];
            r_reg_addr    <= mst_addr[int'(w_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            r_reg_wr_data <= mst_rd_wr_L[w_idx] ? '0
                                                : mst_wr_data[int'(w_idx)*DATA_WIDTH +: DATA_WIDTH];
            r_cnt         <= CW'(TIMEOUT);
            r_state       <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (reg_ack) begin
            r_data    <= reg_rd_data;
            r_to_flag <= 1'b0;
            r_reg_req <= 1'b0;
            r_state   <= RESP;
          end else if (w_timeout) begin
            r_data    <= DATA_WIDTH'(TIMEOUT_DATA);
            r_to_flag <= 1'b1;
            r_reg_req <= 1'b0;
            r_state   <= RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: begin
          r_mst_ack     <= r_grant_oh;
          r_mst_rd_data <= r_reg_rd_wr_L ? r_data : '0;
          r_mst_timeout <= r_to_flag;
          r_rr_ptr      <= (r_grant_idx == PW'(NUM_MASTERS - 1)) ? '0 : r_grant_idx + 1'b1;
          r_state       <= TURN;
        end
        TURN: begin
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mst_ack     = r_mst_ack;
  assign mst_rd_data = r_mst_rd_data;
  assign mst_timeout = r_mst_timeout;
  assign reg_req     = r_reg_req;
  assign reg_rd_wr_L = r_reg_rd_wr_L;
  assign reg_addr    = r_reg_addr;
  assign reg_wr_data = r_reg_wr_data;

`ifdef REG_BUS_ARBITER_STATS_EN
  logic [15:0] r_stat_timeouts;
  logic [15:0] r_stat_grants [NUM_MASTERS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stat_timeouts <= '0;
      for (int i = 0; i < NUM_MASTERS; i++) r_stat_grants[i] <= '0;
    end else begin
      if (w_timeout && r_stat_timeouts != 16'hFFFF)
        r_stat_timeouts <= r_stat_timeouts + 1'b1;
      if (r_state == IDLE && w_valid && r_stat_grants[w_idx] != 16'hFFFF)
        r_stat_grants[w_idx] <= r_stat_grants[w_idx] + 1'b1;
    end
  end

  assign stat_timeouts = r_stat_timeouts;
  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_stat
    assign stat_grants[g*16 +: 16] = r_stat_grants[g];
  end
`endif

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb/tb_reg_bus_arbiter.sv - self-checking bench for reg_bus_arbiter (optional REG_BUS_ARBITER_STATS_EN)
`timescale 1ns/1ps
module tb_reg_bus_arbiter;
  localparam int N  = 2;
  localparam int AW = 25;
  localparam int DW = 32;
  localparam int TO = 511;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    mst_req, mst_rd_wr_L, mst_ack;
  logic [N*AW-1:0] mst_addr;
  logic [N*DW-1:0] mst_wr_data;
  logic [DW-1:0]   mst_rd_data;
  logic            mst_timeout;
  logic            reg_req, reg_rd_wr_L, reg_ack;
  logic [AW-1:0]   reg_addr;
  logic [DW-1:0]   reg_wr_data, reg_rd_data;
`ifdef REG_BUS_ARBITER_STATS_EN
  logic [15:0]     stat_timeouts;
  logic [N*16-1:0] stat_grants;
`endif

  int checks = 0;
  int failures = 0;

  // Reference state: round-robin pointer, per-master request contents, statistics.
  int            m_rr = 0;
  logic          m_rd   [N];
  logic [AW-1:0] m_addr [N];
  logic [DW-1:0] m_wd   [N];
  int            m_grants [N];
  int            m_timeouts = 0;

  int            rl, al, bad, g;
  logic [AW-1:0] o_addr;
  logic          o_rw, o_to;
  logic [DW-1:0] o_wd, o_rd;
  logic [N-1:0]  o_ack;

  reg_bus_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .mst_req(mst_req), .mst_rd_wr_L(mst_rd_wr_L), .mst_addr(mst_addr), .mst_wr_data(mst_wr_data),
    .mst_ack(mst_ack), .mst_rd_data(mst_rd_data), .mst_timeout(mst_timeout),
`ifdef REG_BUS_ARBITER_STATS_EN
    .stat_timeouts(stat_timeouts), .stat_grants(stat_grants),
`endif
    .reg_req(reg_req), .reg_rd_wr_L(reg_rd_wr_L), .reg_addr(reg_addr), .reg_wr_data(reg_wr_data),
    .reg_ack(reg_ack), .reg_rd_data(reg_rd_data)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [N-1:0] r);
    for (int k = 0; k < N; k++) if (r[(m_rr + k) % N]) return (m_rr + k) % N;
    return -1;
  endfunction

  task automatic set_master(input int i, input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m_rd[i] = rd; m_addr[i] = a; m_wd[i] = d;
    mst_rd_wr_L[i] = rd;
    mst_addr[i*AW +: AW] = a;
    mst_wr_data[i*DW +: DW] = d;
  endtask

  // Responds downstream d cycles after reg_req is seen (d<0: never) and observes the result.
  task automatic run_access(input int d, input logic [DW-1:0] rdata);
    int lim;
    rl = 0; al = 0; bad = 0; o_ack = '0; o_rd = '0; o_to = 1'b0;
    lim = (d < 0 || d > TO) ? TO : d;
    while (reg_req !== 1'b1 && rl < 50) begin
      @(posedge clk); #1; rl++;
      if ($countones(mst_ack) > 1) bad++;
    end
    o_addr = reg_addr; o_rw = reg_rd_wr_L; o_wd = reg_wr_data;
    while (al < 2000) begin
      if (al <= lim && (reg_req !== 1'b1 || reg_addr !== o_addr || reg_rd_wr_L !== o_rw || reg_wr_data !== o_wd))
        bad++;
      reg_ack = (al == d);
      reg_rd_data = (al == d) ? rdata : DW'($urandom);
      @(posedge clk); #1; al++;
      if ($countones(mst_ack) > 1) bad++;
      if (mst_ack !== '0) begin
        o_ack = mst_ack; o_rd = mst_rd_data; o_to = mst_timeout;
        break;
      end
    end
    reg_ack = 1'b0;
  endtask

  task automatic account(input int gi, input logic timed_out);
    if (gi >= 0) begin
      m_grants[gi]++;
      m_rr = (gi + 1) % N;
    end
    if (timed_out) m_timeouts++;
  endtask

  task automatic test_reset;
    reset = 1'b0; mst_req = '0; mst_rd_wr_L = '0; mst_addr = '0; mst_wr_data = '0;
    reg_ack = 1'b0; reg_rd_data = '0;
    for (int i = 0; i < N; i++) m_grants[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (mst_ack !== '0) begin failures++; $display("FAIL reset_mst_ack got=%b exp=0", mst_ack); end
    checks++; if (mst_rd_data !== '0) begin failures++; $display("FAIL reset_rd_data got=%h exp=0", mst_rd_data); end
    checks++; if (mst_timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", mst_timeout); end
    checks++; if (reg_req !== 1'b0) begin failures++; $display("FAIL reset_reg_req got=%b exp=0", reg_req); end
    checks++; if (reg_rd_wr_L !== 1'b1) begin failures++; $display("FAIL reset_rd_wr_L got=%b exp=1", reg_rd_wr_L); end
    checks++; if (reg_addr !== '0 || reg_wr_data !== '0) begin failures++; $display("FAIL reset_addr_data got=%h/%h exp=0/0", reg_addr, reg_wr_data); end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_read;
    set_master(0, 1'b1, 25'h0400010, DW'($urandom));
    mst_req = 2'b01;
    g = pick(mst_req);
    run_access(4, 32'h12345678);
    mst_req = '0;
    checks++; if (rl !== 1) begin failures++; $display("FAIL read_req_latency got=%0d exp=1", rl); end
    checks++; if (o_addr !== 25'h0400010 || o_rw !== 1'b1 || o_wd !== '0) begin failures++; $display("FAIL read_bus got=%h/%b/%h exp=0400010/1/0", o_addr, o_rw, o_wd); end
    checks++; if (o_ack !== N'(1 << g)) begin failures++; $display("FAIL read_ack got=%b exp=%b", o_ack, N'(1 << g)); end
    checks++; if (o_rd !== 32'h12345678 || o_to !== 1'b0) begin failures++; $display("FAIL read_data got=%h/%b exp=12345678/0", o_rd, o_to); end
    checks++; if (al !== 6 || bad !== 0) begin failures++; $display("FAIL read_timing got=lat%0d/bad%0d exp=lat6/bad0", al, bad); end
    account(g, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic test_write;
    set_master(1, 1'b0, 25'h0000004, 32'hCAFEF00D);
    mst_req = 2'b10;
    g = pick(mst_req);
    run_access(3, DW'($urandom));
    mst_req = '0;
    checks++; if (o_addr !== 25'h0000004 || o_rw !== 1'b0 || o_wd !== 32'hCAFEF00D) begin failures++; $display("FAIL write_bus got=%h/%b/%h exp=0000004/0/cafef00d", o_addr, o_rw, o_wd); end
    checks++; if (o_ack !== N'(1 << g) || o_rd !== '0 || o_to !== 1'b0) begin failures++; $display("FAIL write_resp got=%b/%h/%b exp=%b/0/0", o_ack, o_rd, o_to, N'(1 << g)); end
    checks++; if (bad !== 0) begin failures++; $display("FAIL write_stable got=%0d exp=0", bad); end
    account(g, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic test_contention;
    for (int i = 0; i < N; i++) set_master(i, 1'b1, AW'($urandom), DW'($urandom));
    mst_req = '1;
    for (int k = 0; k < 6; k++) begin
      logic [DW-1:0] rd;
      rd = DW'($urandom);
      g = pick(mst_req);
      run_access($urandom_range(0, 3), rd);
      checks++; if (o_ack !== N'(1 << g) || o_addr !== m_addr[g] || o_rd !== rd || bad !== 0)
        begin failures++; $display("FAIL contention_%0d got=%b/%h/%h/bad%0d exp=%b/%h/%h/bad0", k, o_ack, o_addr, o_rd, bad, N'(1 << g), m_addr[g], rd); end
      account(g, 1'b0);
    end
    mst_req = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_timeout(input int d);
    logic [DW-1:0] rd;
    logic exp_to;
    rd = DW'($urandom);
    exp_to = (d < 0 || d > TO);
    set_master(0, 1'b1, AW'($urandom), DW'($urandom));
    mst_req = 2'b01;
    g = pick(mst_req);
    run_access(d, rd);
    mst_req = '0;
    checks++; if (al !== (exp_to ? TO + 2 : d + 2)) begin failures++; $display("FAIL timeout_lat_d%0d got=%0d exp=%0d", d, al, exp_to ? TO + 2 : d + 2); end
    checks++; if (o_ack !== N'(1 << g) || o_to !== exp_to || o_rd !== (exp_to ? 32'hDEADBEEF : rd))
      begin failures++; $display("FAIL timeout_resp_d%0d got=%b/%b/%h exp=%b/%b/%h", d, o_ack, o_to, o_rd, N'(1 << g), exp_to, exp_to ? 32'hDEADBEEF : rd); end
    checks++; if (bad !== 0) begin failures++; $display("FAIL timeout_stable_d%0d got=%0d exp=0", d, bad); end
    account(g, exp_to);
`ifdef REG_BUS_ARBITER_STATS_EN
    checks++; if (stat_timeouts !== 16'(m_timeouts)) begin failures++; $display("FAIL stat_timeouts got=%0d exp=%0d", stat_timeouts, m_timeouts); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_access;
    int seen;
    seen = 0;
    set_master(0, 1'b1, AW'($urandom), DW'($urandom));
    mst_req = 2'b01;
    for (int i = 0; i < 10 && reg_req !== 1'b1; i++) begin @(posedge clk); #1; end
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    checks++; if (reg_req !== 1'b0) begin failures++; $display("FAIL midreset_reg_req got=%b exp=0", reg_req); end
    mst_req = '0;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; if (mst_ack !== '0) seen++; end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; if (mst_ack !== '0) seen++; end
    checks++; if (seen !== 0) begin failures++; $display("FAIL midreset_no_ack got=%0d exp=0", seen); end
    m_rr = 0; m_timeouts = 0;
    for (int i = 0; i < N; i++) m_grants[i] = 0;
    set_master(1, 1'b1, AW'($urandom), DW'($urandom));
    mst_req = 2'b10;
    g = pick(mst_req);
    run_access(2, 32'h0BADF00D);
    mst_req = '0;
    checks++; if (rl !== 1 || o_ack !== N'(1 << g) || o_rd !== 32'h0BADF00D || o_addr !== m_addr[1])
      begin failures++; $display("FAIL midreset_recover got=%0d/%b/%h/%h exp=1/%b/0badf00d/%h", rl, o_ack, o_rd, o_addr, N'(1 << g), m_addr[1]); end
    account(g, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    for (int k = 0; k < 16; k++) begin
      logic [N-1:0] r;
      logic [DW-1:0] rd;
      int d, stray;
      stray = 0;
      reg_ack = 1'b1;
      @(posedge clk); #1;
      reg_ack = 1'b0;
      @(posedge clk); #1;
      if (mst_ack !== '0 || reg_req !== 1'b0) stray++;
      checks++; if (stray !== 0) begin failures++; $display("FAIL stray_ack_%0d got=%b/%b exp=0/0", k, mst_ack, reg_req); end
      for (int i = 0; i < N; i++) set_master(i, 1'($urandom), AW'($urandom), DW'($urandom));
      r = N'($urandom_range(1, (1 << N) - 1));
      rd = DW'($urandom);
      d = $urandom_range(0, 6);
      mst_req = r;
      g = pick(r);
      run_access(d, rd);
      mst_req = '0;
      checks++; if (o_ack !== N'(1 << g) || o_addr !== m_addr[g] || o_rw !== m_rd[g] || o_wd !== (m_rd[g] ? '0 : m_wd[g]))
        begin failures++; $display("FAIL random_bus_%0d got=%b/%h/%b/%h exp=%b/%h/%b/%h", k, o_ack, o_addr, o_rw, o_wd, N'(1 << g), m_addr[g], m_rd[g], m_rd[g] ? '0 : m_wd[g]); end
      checks++; if (o_rd !== (m_rd[g] ? rd : '0) || o_to !== 1'b0 || al !== d + 2 || bad !== 0)
        begin failures++; $display("FAIL random_resp_%0d got=%h/%b/lat%0d/bad%0d exp=%h/0/lat%0d/bad0", k, o_rd, o_to, al, bad, m_rd[g] ? rd : '0, d + 2); end
      account(g, 1'b0);
    end
  endtask

  task automatic test_stats;
`ifdef REG_BUS_ARBITER_STATS_EN
    for (int i = 0; i < N; i++) begin
      checks++; if (stat_grants[i*16 +: 16] !== 16'(m_grants[i]))
        begin failures++; $display("FAIL stat_grants_%0d got=%0d exp=%0d", i, stat_grants[i*16 +: 16], m_grants[i]); end
    end
`endif
  endtask

  initial begin
    test_reset;
    test_single_read;
    test_write;
    test_contention;
    test_timeout(-1);
    test_timeout(TO);
    test_timeout(TO + 1);
    test_stats;
    test_reset_mid_access;
    test_random;
    test_stats;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
